// File: rtl/out_col_fifo_pkg.sv
// out_col_fifo_pkg: shared array dimensions and pointer-width helper for the output collector.
package out_col_fifo_pkg;
  localparam int PSUM_BW = 16;
  localparam int COL = 8;
  function automatic int ptr_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/col_fifo.sv
// col_fifo: single-lane circular buffer; a write to a full lane is accepted only alongside a pop.
module col_fifo
  import out_col_fifo_pkg::*;
#(
  parameter int psum_bw = PSUM_BW,
  parameter int depth = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr,
  input  logic [psum_bw-1:0]      din,
  input  logic                    pop,
  output logic [psum_bw-1:0]      dout,
  output logic [ptr_w(depth):0]   count
);
  localparam int aw = ptr_w(depth);
  localparam int cw = aw + 1;
  logic [psum_bw-1:0] mem [depth];
  logic [aw-1:0] wp, rp;
  logic acc;
  // pop is only asserted when every lane is non-empty, so it always frees a slot here
  assign acc = wr && (count < cw'(depth) || pop);
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (acc) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + cw'(acc) - cw'(pop);
    end
  end
  always_ff @(posedge clk)
    if (acc) mem[wp] <= din;
endmodule

// File: rtl/out_col_fifo.sv
// out_col_fifo: realigns skewed MAC-array column outputs into full-width rows popped one per handshake.
module out_col_fifo
  import out_col_fifo_pkg::*;
#(
  parameter int col = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [psum_bw*col-1:0]   in,
  input  logic [col-1:0]           wr,
  input  logic                     rd,
  output logic [psum_bw*col-1:0]   out,
  output logic                     o_valid,
  output logic                     o_full,
  output logic                     o_ready,
  output logic                     o_overflow
);
  localparam int cw = ptr_w(depth) + 1;
  logic [cw-1:0] cnt [col];
  logic [psum_bw*col-1:0] head;
  logic [col-1:0] ne, fl, rm;
  logic pop;
  assign pop = rd && o_valid;
  for (genvar j = 0; j < col; j++) begin : g_lane
    col_fifo #(.psum_bw(psum_bw), .depth(depth)) u_fifo (
      .clk(clk),
      .reset(reset),
      .wr(wr[j]),
      .din(in[psum_bw*j +: psum_bw]),
      .pop(pop),
      .dout(head[psum_bw*j +: psum_bw]),
      .count(cnt[j])
    );
    assign ne[j] = cnt[j] != '0;
    assign fl[j] = cnt[j] == cw'(depth);
    // room left for one full skewed wave of writes
    assign rm[j] = cnt[j] <= cw'(depth - col);
  end
  assign o_valid = &ne;
  assign o_full = |fl;
  assign o_ready = &rm;
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (pop) out <= head;
      if (|(wr & fl) && !pop) o_overflow <= 1'b1;
    end
  end
endmodule

// File: doc/out_col_fifo.md
# out_col_fifo

Output-side collector that sits directly downstream of the MAC array. It captures each column's partial sum whenever that column's `valid` bit fires. Because of the array's diagonal skew, column j emits one cycle after column j-1. The block realigns the columns into full-width rows that the accumulation/SFU stage reads one row per handshake.

## Interface
- `col`, 8: number of array columns (independent FIFO lanes).
- `psum_bw`, 16: partial-sum width per column.
- `depth`, 16: entries per column FIFO; power of two, ≥2.
- `clk`  in  1  rising-edge clock, single domain.
- `reset`  in  1  synchronous, active-high reset.
- `in`  in  psum_bw*col  array `out_s`; lane j = bits [psum_bw*j +: psum_bw].
- `wr`  in  col  array `valid`; bit j writes lane j.
- `rd`  in  1  pop one aligned row; honoured only when `o_valid`=1.
- `out`  out  psum_bw*col  registered aligned row, lane j from column FIFO j.
- `o_valid`  out  1  every lane holds ≥1 entry.
- `o_full`  out  1  any lane holds `depth` entries.
- `o_ready`  out  1  every lane holds ≤ depth-col entries (room for one skewed wave).
- `o_overflow`  out  1  sticky: some write was dropped.

## Operation
- Per lane: circular buffer, write pointer, read pointer, occupancy count of log2(depth)+1 bits. Pointers wrap modulo `depth`.
- Write to lane j when `wr[j]`=1:
  - Accepted if count_j < depth.
  - Also accepted if count_j = depth and a row pop occurs in the same cycle.
  - Otherwise the write is dropped, data is discarded, and `o_overflow` is set to 1.
- Lanes are independent; any subset of `wr` bits may be high in a cycle.
- Pop (`rd`=1 and `o_valid`=1): all lanes advance their read pointer together. `out` loads the head entries.
- `rd`=1 with `o_valid`=0 is ignored. Pointers and `out` hold, and no error is flagged.
- Simultaneous write and pop on a lane: the count is unchanged and both pointers advance.
- A write to an empty lane never bypasses to `out`. A lane must be non-empty before the cycle in which it can be popped.
- `out` holds its value between pops.
- Data passes through unmodified. No sign extension or arithmetic.

## Timing
- Reset, at the clock edge with `reset`=1:
  - All pointers and counts are 0.
  - `out` = 0, `o_valid` = 0, `o_full` = 0, `o_ready` = 1, `o_overflow` = 0.
  - Buffer contents are don't-care.
- Reset overrides `wr` and `rd` in the same cycle.
- Reset mid-operation discards all stored data.
- Status outputs (`o_valid`, `o_full`, `o_ready`) are combinational from registered counts. They reflect writes and pops one cycle after the edge that applied them.
- Write latency: a lane written at edge N counts toward `o_valid` after edge N.
- Read latency: a pop accepted at edge N presents data on `out` after edge N (1 cycle).
- Skew: with column j first written at edge N+j, `o_valid` first rises after edge N+col-1. Under continuous writes and `rd` held at 1, the block then sustains one pop per cycle.
- `o_overflow` clears only on reset.

## Structure
- Shared package constants:
  - `PSUM_BW` = 16 and `COL` = 8 for the array.
  - Pointer width function clog2(depth).
- Sub-module `col_fifo` is the single-lane FIFO, instantiated `col` times in a generate loop.
  - Ports: clk, reset, wr, din, pop, dout, count.
  - `pop` is driven by the shared row-pop signal.
- Top level contains the row-pop logic, the status reduction (AND/OR over lanes), the registered `out`, and the sticky overflow flag.

## Test plan
- **Reset:** apply `reset` for 2 cycles with `wr`=8'hFF → `out`=0, `o_valid`=0, `o_ready`=1, `o_overflow`=0; nothing is stored.
- **Skewed single row:**
  - Stimulus: lane j written value 16'h0100+j at cycle j (j=0..7).
  - Expected: `o_valid` rises one cycle after the lane-7 write.
  - Expected: `rd` then gives `out` lanes = 0x0100..0x0107 one cycle later, and `o_valid` falls.
- **Streaming:** 20 skewed rows with row r, lane j = r*16+j, and `rd` held at 1 → rows come out in order with no gaps after the first. No overflow.
- **Full boundary (depth=16):**
  - Write 16 entries to every lane with no `rd` → `o_full`=1 and `o_ready`=0.
  - A 17th write on lane 3 alone → dropped, `o_overflow`=1, and later reads return the first 16 values only.
- **Full with simultaneous pop:** full FIFO, `rd`=1 and `wr`=8'hFF in the same cycle → the write is accepted, counts stay 16, `o_overflow` stays 0, and FIFO order is preserved.
- **Wrap and illegal read:**
  - Push and pop 40 rows → pointers wrap twice and data stays correct.
  - `rd`=1 while empty → `out` holds its last value and no pointer moves.
